// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage of the 9-bit core.
// Holds the fetch FSM state type, the opcode constants the fetch stage
// recognises, the default PC width and a small opcode helper.
package fetch_pkg;

  localparam int PW_DEFAULT = 10;

  localparam logic [2:0] OP_BRANCH = 3'b110;
  localparam logic [2:0] OP_HALT   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  function automatic logic op_is_halt(input logic [2:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch stage and its neighbours (ROM, decoder, ALU,
// program-level controller).
//   master : environment side -- drives Start, Instr, decoder controls,
//            BranchData, ALUResult; observes PC, Run, Done, flags, State.
//   slave  : fetch_sequencer side.
//
// Program handshake: Start (level or pulse) is accepted only while the
// fetch stage is in IDLE or DONE and launches execution at START_ADDR on
// that clock edge. Run is high in every cycle whose instruction must take
// effect and is the only qualifier for downstream writes. Done rises the
// cycle after a HALT is presented and stays high until the next accepted
// Start. Start while running is ignored.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int PW = PW_DEFAULT
);
  logic          Start;
  logic [8:0]    Instr;
  logic          AbsBranch;
  logic          RelBranch;
  logic          BranchFlag;
  logic          BranchInvert;
  logic          RegWrite;
  logic [7:0]    BranchData;
  logic [7:0]    ALUResult;
  logic [PW-1:0] ProgAddr;
  logic          Run;
  logic          Done;
  logic          ZeroFlag;
  logic          NegFlag;
  fetch_state_t  State;     // debug view of the fetch FSM

  modport master (
    output Start, Instr, AbsBranch, RelBranch, BranchFlag, BranchInvert,
           RegWrite, BranchData, ALUResult,
    input  ProgAddr, Run, Done, ZeroFlag, NegFlag, State
  );

  modport slave (
    input  Start, Instr, AbsBranch, RelBranch, BranchFlag, BranchInvert,
           RegWrite, BranchData, ALUResult,
    output ProgAddr, Run, Done, ZeroFlag, NegFlag, State
  );
endinterface

// File: rtl/branch_resolve.sv
// Combinational branch resolution for the fetch stage.
// Ports:
//   pc            in  current program counter
//   abs_branch    in  absolute branch request (wins over relative)
//   rel_branch    in  relative branch request
//   branch_flag   in  0 = test zero flag, 1 = test negative flag
//   branch_invert in  invert the tested flag
//   zero_flag     in  registered zero flag
//   neg_flag      in  registered negative flag
//   branch_data   in  target (absolute, zero-extended) or offset
//                     (relative, sign-extended)
//   taken         out tested flag after optional inversion
//   next_pc       out PC for the next instruction, modulo 2^PW
module branch_resolve #(
  parameter int PW = 10
) (
  input  logic [PW-1:0] pc,
  input  logic          abs_branch,
  input  logic          rel_branch,
  input  logic          branch_flag,
  input  logic          branch_invert,
  input  logic          zero_flag,
  input  logic          neg_flag,
  input  logic [7:0]    branch_data,
  output logic          taken,
  output logic [PW-1:0] next_pc
);

  logic [PW-1:0] abs_target;
  logic [PW-1:0] rel_target;

  assign taken      = (branch_flag ? neg_flag : zero_flag) ^ branch_invert;
  assign abs_target = {{(PW-8){1'b0}}, branch_data};
  // Offset is two's complement; the add naturally wraps at 2^PW.
  assign rel_target = pc + {{(PW-8){branch_data[7]}}, branch_data};

  always_comb begin
    next_pc = pc + PW'(1);
    if (abs_branch && taken) begin
      next_pc = abs_target;
    end else if (rel_branch && taken) begin
      next_pc = rel_target;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage: owns the PC, the IDLE/RUN/DONE program FSM and
// the zero/negative flag register used for conditional branches.
// Ports:
//   Clk      in  system clock, rising edge
//   Reset_n  in  asynchronous active-low reset
//   bus      slave side of fetch_sequencer_if (Start, Instr, decoder
//            branch controls, RegWrite, BranchData, ALUResult in;
//            ProgAddr, Run, Done, ZeroFlag, NegFlag, State out)
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int            PW         = PW_DEFAULT,
  parameter logic [PW-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset_n,
  fetch_sequencer_if.slave bus
);

  fetch_state_t  state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          zero_q, zero_d;
  logic          neg_q, neg_d;

  logic [PW-1:0] next_pc;
  logic          branch_taken_unused;
  logic          halt;
  logic          unused_instr_bits;

  // Only the opcode field matters to fetch; operand bits belong to the decoder.
  assign unused_instr_bits = ^bus.Instr[5:0];
  assign halt              = op_is_halt(bus.Instr[8:6]);

  branch_resolve #(.PW(PW)) u_branch_resolve (
    .pc            (pc_q),
    .abs_branch    (bus.AbsBranch),
    .rel_branch    (bus.RelBranch),
    .branch_flag   (bus.BranchFlag),
    .branch_invert (bus.BranchInvert),
    .zero_flag     (zero_q),
    .neg_flag      (neg_q),
    .branch_data   (bus.BranchData),
    .taken         (branch_taken_unused),
    .next_pc       (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
          zero_d  = 1'b0;
          neg_d   = 1'b0;
        end
      end
      RUN: begin
        if (halt) begin
          // HALT is not executed: PC and flags freeze where they are.
          state_d = DONE;
        end else begin
          pc_d = next_pc;
          if (bus.RegWrite) begin
            zero_d = (bus.ALUResult == 8'h00);
            neg_d  = bus.ALUResult[7];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  // Run is combinational so it drops in the very cycle a HALT appears and
  // the instant reset asserts.
  assign bus.Run      = (state_q == RUN) && !halt;
  assign bus.Done     = (state_q == DONE);
  assign bus.ProgAddr = pc_q;
  assign bus.ZeroFlag = zero_q;
  assign bus.NegFlag  = neg_q;
  assign bus.State    = state_q;

endmodule
